// File: rtl/user_io_ext_if.sv
// ---------------------------------------------------------------------------
// user_io_ext_if
// Purpose : bundles the loaned HPS GPIO pins and the core-side button/LED
//           signals of user_io_ext into one interface.
// Signals : user_btn     raw button pins, active low (pull-ups)
//           user_led     LED pins, active high
//           btn_level    debounced button state, 1 = pressed
//           btn_pressed  1-cycle pulse on debounced press
//           btn_released 1-cycle pulse on debounced release
//           btn_long     1-cycle pulse when a press has been held long enough
//           led_mode     3-bit mode per LED, bits [3i+2:3i] belong to LED i
//           led_bright   PWM_BITS brightness per LED, used in mode 5
// Modports: master = pins/core side (drives buttons, modes, brightness)
//           slave  = user_io_ext itself
// There is no valid/ready handshake here: every signal is a level or a
// single-cycle pulse, sampled or produced on every clock edge.
// ---------------------------------------------------------------------------
interface user_io_ext_if #(
    parameter int NUM_BTN  = 2,
    parameter int NUM_LED  = 4,
    parameter int PWM_BITS = 4
);
    logic [NUM_BTN-1:0]          user_btn;
    logic [NUM_LED-1:0]          user_led;
    logic [NUM_BTN-1:0]          btn_level;
    logic [NUM_BTN-1:0]          btn_pressed;
    logic [NUM_BTN-1:0]          btn_released;
    logic [NUM_BTN-1:0]          btn_long;
    logic [3*NUM_LED-1:0]        led_mode;
    logic [PWM_BITS*NUM_LED-1:0] led_bright;

    modport master (
        output user_btn, led_mode, led_bright,
        input  user_led, btn_level, btn_pressed, btn_released, btn_long
    );

    modport slave (
        input  user_btn, led_mode, led_bright,
        output user_led, btn_level, btn_pressed, btn_released, btn_long
    );
endinterface

// File: rtl/user_io_ext.sv
// ---------------------------------------------------------------------------
// user_io_ext
// Purpose : user I/O controller for the GPIO pins loaned from the HPS.
//           Buttons: 2-flop sync, counter debounce, press/release/long pulses.
//           LEDs   : per-LED mode (off, on, slow/fast blink, inverted fast
//                    blink, PWM brightness) driven from shared counters.
// Ports   : clk    system clock
//           reset  asynchronous, active-high reset
//           io     user_io_ext_if.slave (pins, debounced state, pulses,
//                  LED mode and brightness)
// ---------------------------------------------------------------------------
module user_io_ext #(
    parameter int NUM_BTN     = 2,
    parameter int NUM_LED     = 4,
    parameter int DEB_CYCLES  = 500000,
    parameter int LONG_CYCLES = 50000000,
    parameter int SLOW_BIT    = 24,
    parameter int FAST_BIT    = 22,
    parameter int PWM_BITS    = 4
) (
    input  logic         clk,
    input  logic         reset,
    user_io_ext_if.slave io
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int BW = SLOW_BIT + 1;

    // Button state. sync*_q hold the inverted (1 = pressed) pin level.
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] stable_q, stable_d;
    logic [NUM_BTN-1:0] prev_q;
    logic [NUM_BTN-1:0] pressed_q, pressed_d;
    logic [NUM_BTN-1:0] released_q, released_d;
    logic [NUM_BTN-1:0] long_q, long_d;
    logic [DW-1:0]      deb_cnt_q [NUM_BTN];
    logic [DW-1:0]      deb_cnt_d [NUM_BTN];
    logic [HW-1:0]      hold_cnt_q [NUM_BTN];
    logic [HW-1:0]      hold_cnt_d [NUM_BTN];

    // LED state.
    logic [BW-1:0]       blink_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [NUM_LED-1:0]  led_q, led_d;

    always_comb begin
        stable_d   = stable_q;
        pressed_d  = '0;
        released_d = '0;
        long_d     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_d[i]  = '0;
            hold_cnt_d[i] = '0;

            // Debounce: any cycle matching the stable value restarts the count.
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end

            // Edge pulses come one cycle after stable changes.
            pressed_d[i]  = stable_q[i] & ~prev_q[i];
            released_d[i] = ~stable_q[i] & prev_q[i];

            // The hold count starts alongside the press pulse, so btn_long
            // lands exactly LONG_CYCLES after btn_pressed. Requiring
            // stable_q keeps it disjoint from the release pulse.
            if (stable_q[i] && prev_q[i]) begin
                if (hold_cnt_q[i] == HW'(LONG_CYCLES)) begin
                    hold_cnt_d[i] = hold_cnt_q[i];
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                end
                long_d[i] = (hold_cnt_q[i] == HW'(LONG_CYCLES - 1));
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (io.led_mode[3*i +: 3])
                3'd1:    led_d[i] = 1'b1;
                3'd2:    led_d[i] = blink_cnt_q[SLOW_BIT];
                3'd3:    led_d[i] = blink_cnt_q[FAST_BIT];
                3'd4:    led_d[i] = ~blink_cnt_q[FAST_BIT];
                3'd5:    led_d[i] = (pwm_cnt_q < io.led_bright[PWM_BITS*i +: PWM_BITS]);
                default: led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            prev_q      <= '0;
            pressed_q   <= '0;
            released_q  <= '0;
            long_q      <= '0;
            blink_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= ~io.user_btn;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            prev_q      <= stable_q;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            long_q      <= long_d;
            blink_cnt_q <= blink_cnt_q + BW'(1);
            pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
            led_q       <= led_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign io.btn_level    = stable_q;
    assign io.btn_pressed  = pressed_q;
    assign io.btn_released = released_q;
    assign io.btn_long     = long_q;
    assign io.user_led     = led_q;
endmodule

// File: tb/tb_user_io_ext.sv
// ---------------------------------------------------------------------------
// tb_user_io_ext
// Purpose : self-checking bench for user_io_ext with small debounce, hold,
//           blink and PWM parameters. LED modes run from a vector table;
//           button debounce, long press and reset corners are hand sequences.
// ---------------------------------------------------------------------------
module tb_user_io_ext;
    localparam int NB = 2;
    localparam int NL = 4;
    localparam int PB = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    user_io_ext_if #(.NUM_BTN(NB), .NUM_LED(NL), .PWM_BITS(PB)) io ();

    user_io_ext #(
        .NUM_BTN(NB), .NUM_LED(NL), .DEB_CYCLES(4), .LONG_CYCLES(20),
        .SLOW_BIT(4), .FAST_BIT(2), .PWM_BITS(PB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    // Time base: number of active edges since reset was last released.
    int ecnt;
    always @(posedge clk or posedge reset) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int press_cnt [NB];
    int rel_cnt   [NB];
    int long_cnt  [NB];
    int press_at  [NB];
    int long_at   [NB];
    bit overlap_seen;
    bit lvl1_seen;

    typedef struct packed {
        logic [3*NL-1:0]  mode;
        logic [PB*NL-1:0] bright;
        logic [3:0][5:0]  exp_high;  // high cycles per LED in a 32-cycle window
    } led_vec_t;

    led_vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NB; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            long_cnt[i]  = 0;
            press_at[i]  = -1;
            long_at[i]   = -1;
        end
        overlap_seen = 1'b0;
        lvl1_seen    = 1'b0;
    endtask

    // One clock: advance past the active edge, sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NB; i++) begin
            if (io.btn_pressed[i])  begin press_cnt[i]++; press_at[i] = cyc; end
            if (io.btn_released[i]) rel_cnt[i]++;
            if (io.btn_long[i])     begin long_cnt[i]++; long_at[i] = cyc; end
            if (io.btn_pressed[i] && io.btn_released[i]) overlap_seen = 1'b1;
            if (io.btn_long[i] && io.btn_released[i])    overlap_seen = 1'b1;
        end
        if (io.btn_level[1]) lvl1_seen = 1'b1;
    endtask

    function automatic logic exp_led(input logic [2:0] m, input logic [PB-1:0] b, input int t);
        logic [4:0]    bc;
        logic [PB-1:0] pc;
        bc = t[4:0];
        pc = t[PB-1:0];
        case (m)
            3'd1:    return 1'b1;
            3'd2:    return bc[4];
            3'd3:    return bc[2];
            3'd4:    return ~bc[2];
            3'd5:    return (pc < b);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lvl_at, c0, p, t, tgt, hi [NL];
        logic [NL-1:0] expv;

        vecs[0] = '{12'o4321, 8'h00, {6'd16, 6'd16, 6'd16, 6'd32}};
        vecs[1] = '{12'o5555, 8'he4, {6'd24, 6'd16, 6'd8,  6'd0}};
        vecs[2] = '{12'o6705, 8'h03, {6'd0,  6'd0,  6'd0,  6'd24}};
        vecs[3] = '{12'o1111, 8'h00, {6'd32, 6'd32, 6'd32, 6'd32}};
        vecs[4] = '{12'o0000, 8'hff, {6'd0,  6'd0,  6'd0,  6'd0}};
        vecs[5] = '{12'o3335, 8'h01, {6'd16, 6'd16, 6'd16, 6'd8}};
        vecs[6] = '{12'o4244, 8'h00, {6'd16, 6'd16, 6'd16, 6'd16}};

        // ---- reset with both buttons held ----
        reset         = 1'b1;
        io.user_btn   = 2'b00;
        io.led_mode   = '0;
        io.led_bright = '0;
        cyc           = 0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_level",    io.btn_level,    0);
        check("rst_pressed",  io.btn_pressed,  0);
        check("rst_released", io.btn_released, 0);
        check("rst_long",     io.btn_long,     0);
        check("rst_led",      io.user_led,     0);

        reset = 1'b0;
        cyc   = 0;
        clear_stats();
        lvl_at = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (lvl_at < 0 && io.btn_level == 2'b11) lvl_at = cyc;
        end
        check_range("exit_level_latency", lvl_at, 5, 7);
        check("exit_press_cnt0", press_cnt[0], 1);
        check("exit_press_cnt1", press_cnt[1], 1);
        check("exit_press_at0",  press_at[0], lvl_at + 1);
        check("exit_rel_cnt0",   rel_cnt[0], 0);
        check("exit_rel_cnt1",   rel_cnt[1], 0);

        // ---- LED mode table ----
        for (int v = 0; v < 7; v++) begin
            io.led_mode   = vecs[v].mode;
            io.led_bright = vecs[v].bright;
            for (int l = 0; l < NL; l++) hi[l] = 0;
            for (int c = 0; c < 32; c++) begin
                tick();
                t = ecnt - 1;
                for (int l = 0; l < NL; l++)
                    expv[l] = exp_led(vecs[v].mode[3*l +: 3], vecs[v].bright[PB*l +: PB], t);
                check($sformatf("led_vec%0d_t%0d", v, c), io.user_led, expv);
                for (int l = 0; l < NL; l++) hi[l] += int'(io.user_led[l]);
            end
            for (int l = 0; l < NL; l++)
                check($sformatf("led_vec%0d_high%0d", v, l), hi[l], int'(vecs[v].exp_high[l]));
        end

        // ---- mode change shows up one cycle later ----
        io.led_mode = '0;
        tick();
        io.led_mode = 12'o0001;
        check("mode_chg_before", io.user_led[0], 0);
        tick();
        check("mode_chg_after", io.user_led[0], 1);
        io.led_mode = 12'o0006;
        tick();
        check("mode6_off_a", io.user_led[0], 0);
        repeat (9) tick();
        check("mode6_off_b", io.user_led[0], 0);

        // ---- bounce on button 0, button 1 released ----
        io.user_btn = 2'b11;
        repeat (15) tick();
        check("release_all_level", io.btn_level, 0);
        clear_stats();
        c0 = cyc;
        io.user_btn[0] = 1'b0;
        repeat (3) tick();
        io.user_btn[0] = 1'b1;
        tick();
        io.user_btn[0] = 1'b0;
        repeat (12) tick();
        check("bounce_press_cnt0", press_cnt[0], 1);
        check_range("bounce_press_at0", press_at[0], c0 + 10, c0 + 12);
        check("bounce_press_cnt1", press_cnt[1], 0);
        check("bounce_lvl1", lvl1_seen, 0);

        // ---- long press: hold 30 cycles past the press pulse ----
        p   = press_at[0];
        tgt = (p < 0) ? cyc : p + 30;
        for (int k = 0; k < 40 && cyc < tgt; k++) tick();
        check("long_cnt0",  long_cnt[0], 1);
        check("long_at0",   long_at[0], p + 20);
        io.user_btn[0] = 1'b1;
        repeat (10) tick();
        check("long_rel_cnt0",  rel_cnt[0], 1);
        check("long_cnt0_once", long_cnt[0], 1);
        check("long_rel_level", io.btn_level[0], 0);
        check("long_overlap",   overlap_seen, 0);

        // ---- short press: 10-cycle hold gives no btn_long ----
        clear_stats();
        io.user_btn[0] = 1'b0;
        for (int k = 0; k < 15 && press_cnt[0] == 0; k++) tick();
        repeat (10) tick();
        io.user_btn[0] = 1'b1;
        repeat (30) tick();
        check("short_press_cnt0", press_cnt[0], 1);
        check("short_long_cnt0",  long_cnt[0], 0);
        check("short_rel_cnt0",   rel_cnt[0], 1);
        check("short_overlap",    overlap_seen, 0);

        // ---- async reset 10 cycles into a long press ----
        clear_stats();
        io.led_mode    = 12'o1111;
        io.user_btn[0] = 1'b0;
        for (int k = 0; k < 15 && press_cnt[0] == 0; k++) tick();
        repeat (10) tick();
        check("mid_no_long_yet", long_cnt[0], 0);
        check("mid_level_before", io.btn_level[0], 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_level", io.btn_level, 0);
        check("mid_rst_led",   io.user_led,  0);
        check("mid_rst_pulses", {io.btn_pressed, io.btn_released, io.btn_long}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        clear_stats();
        repeat (35) tick();
        check("post_rst_press_cnt0", press_cnt[0], 1);
        check_range("post_rst_press_at0", press_at[0], 6, 8);
        check("post_rst_long_cnt0", long_cnt[0], 1);
        check("post_rst_long_at0",  long_at[0], press_at[0] + 20);
        check("post_rst_rel_cnt0",  rel_cnt[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/user_io_ext.md
Name: user_io_ext

Overview:
Parametrised user I/O controller for the GPIO pins loaned from the HPS. It drives NUM_LED LEDs and monitors NUM_BTN buttons.
- Buttons: per-button synchronisation, counter-based debounce, press/release/long-press pulses.
- LEDs: per-LED mode select covering solid, two blink rates, inverted blink and PWM brightness.
- Sits between the top-level loaned pins and core logic.

Parameters:
NUM_BTN, 2, number of buttons (1..16)
NUM_LED, 4, number of LEDs (1..16)
DEB_CYCLES, 500000, cycles the synced input must differ from the stable state before it is accepted (10 ms at 50 MHz); must be >= 2
LONG_CYCLES, 50000000, cycles a debounced press must be held before btn_long fires (1 s at 50 MHz); must be > DEB_CYCLES
SLOW_BIT, 24, blink counter bit used for slow blink
FAST_BIT, 22, blink counter bit used for fast blink; must be < SLOW_BIT
PWM_BITS, 4, per-LED brightness resolution

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
user_btn  in  NUM_BTN  raw button pins, active low (pull-ups)
user_led  out  NUM_LED  LED pins, active high
btn_level  out  NUM_BTN  debounced state, 1 = pressed
btn_pressed  out  NUM_BTN  1-cycle pulse on debounced press
btn_released  out  NUM_BTN  1-cycle pulse on debounced release
btn_long  out  NUM_BTN  1-cycle pulse when a press has been held LONG_CYCLES
led_mode  in  3*NUM_LED  mode per LED; bits [3i+2:3i] belong to LED i
led_bright  in  PWM_BITS*NUM_LED  brightness per LED for mode 5

Behaviour:
Reset (async assert, sync release):
- All outputs are 0.
- Sync flops are set to the released level.
- Debounced state is released.
- Debounce, hold, blink and PWM counters are 0.
- Asserting reset mid-debounce or mid-hold discards the progress. There are no pulses on reset exit, even if a button is already held; that press is reported after a full debounce.

Button path (per button i, all buttons independent):
- Sync: 2-flop synchroniser of ~user_btn[i].
- Debounce counter:
  - Clears when the synced value equals the stable value.
  - Otherwise increments each cycle.
  - When it has counted DEB_CYCLES consecutive differing cycles, stable takes the synced value and the counter clears.
  - Any bounce back to the stable value before that restarts the count.
- Latency: a clean raw edge at cycle 0 changes btn_level at cycle 2+DEB_CYCLES (±1).
- Pulses:
  - btn_pressed is high for exactly one cycle, the cycle after stable rises.
  - btn_released is high for exactly one cycle, the cycle after stable falls.
  - Press and release pulses are registered and never overlap for the same button.
- Hold counter:
  - Counts while stable = 1 and saturates at LONG_CYCLES.
  - btn_long pulses once, for 1 cycle, when the count reaches LONG_CYCLES. No auto-repeat.
  - Clears on release.
  - A release before LONG_CYCLES produces no btn_long.
  - btn_long and btn_released never occur in the same cycle for one button.

LED path:
- blink_cnt: free-running, SLOW_BIT+1 bits, wraps to 0.
- pwm_cnt: free-running, PWM_BITS bits, wraps.
- Mode per LED:
  - 0: off
  - 1: on
  - 2: blink_cnt[SLOW_BIT]
  - 3: blink_cnt[FAST_BIT]
  - 4: ~blink_cnt[FAST_BIT]
  - 5: PWM, on when pwm_cnt < bright (unsigned)
  - 6, 7: off (reserved)
- PWM duty: bright = 0 is always off; bright = 2^PWM_BITS−1 is on for 2^PWM_BITS−1 of every 2^PWM_BITS cycles.
- user_led is registered, so a mode or brightness change appears one cycle later.
- All LEDs share the counters, so LEDs in the same blink mode are phase-aligned.

Test Plan:
Bench parameters: NUM_BTN=2, NUM_LED=4, DEB_CYCLES=4, LONG_CYCLES=20, SLOW_BIT=4, FAST_BIT=2, PWM_BITS=2.
1. Reset: hold reset with user_btn=2'b00 (both held) -> all outputs 0. Release reset -> btn_level[1:0]=2'b11 after 2+4 cycles (±1), one btn_pressed pulse per button, no btn_released.
2. Bounce: drive user_btn[0] low for 3 cycles, high for 1, then low steadily -> no pulse during the bounce. btn_pressed[0] pulses once, 4 cycles after the last edge plus sync latency. btn_level[1] stays 0 throughout.
3. Long press: hold button 0 for 30 cycles after debounce -> btn_long[0] pulses exactly once, 20 cycles after btn_pressed[0]. Release -> btn_released[0] pulses once. Repeat with a 10-cycle hold -> no btn_long.
4. LED modes: led_mode = {3'd4, 3'd3, 3'd2, 3'd1} -> LED0 constant 1; LED1 period 32 cycles; LED2 period 8 cycles; LED3 is the exact inverse of LED2. Mode change -> LED updates after 1 cycle.
5. PWM: LED0 mode 5 with bright 0, 1, 3 -> high 0, 1 and 3 of every 4 cycles respectively. Mode 6 -> LED constant 0.
6. Async reset mid-hold: assert reset 10 cycles into a long press -> outputs clear immediately. After release of reset with the button still held -> new btn_pressed after a full debounce, btn_long 20 cycles later.
